// File: rtl/mem_speed_test.sv
// mem_speed_test: write-then-verify memory bandwidth sequencer over a single-master word bus
// Ports: clk/rst (sync, active-high); start launches a run from IDLE or DONE;
// mem_stb/mem_we/mem_addr/mem_data_out/mem_data_in/mem_ack form the bus;
// busy/done/pass/err_count/first_err_addr/cycle_count report progress and results.
module mem_speed_test #(
  parameter int          ADDR_WIDTH  = 22,
  parameter int          NUM_WORDS   = 1024,
  parameter logic [31:0] PATTERN_KEY = 32'hA5A55A5A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_stb,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data_out,
  input  logic [31:0]           mem_data_in,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [31:0]           cycle_count
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  // termination is by matching the last address, so a full 2^ADDR_WIDTH sweep never relies on wrap
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);
  function automatic logic [31:0] pat(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) ^ PATTERN_KEY;
  endfunction
  state_t                  r_state, w_state;
  logic                    r_stb, w_stb, r_we, w_we, r_pass, w_pass;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr, r_first, w_first;
  logic [31:0]             r_dout, w_dout, r_cyc, w_cyc;
  logic [15:0]             r_err, w_err;
  logic                    w_xfer, w_last, w_mis, w_busy;
  logic [ADDR_WIDTH-1:0]   w_next;
  assign w_busy = (r_state == WRITE) || (r_state == READ);
  assign w_xfer = r_stb && mem_ack;
  assign w_last = r_addr == LAST;
  assign w_next = r_addr + 1'b1;
  assign w_mis  = (r_state == READ) && w_xfer && (mem_data_in != pat(r_addr));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state;
      r_stb   <= w_stb;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_dout  <= w_dout;
      r_pass  <= w_pass;
      r_err   <= w_err;
      r_first <= w_first;
      r_cyc   <= w_cyc;
    end
  end
  always_comb begin
    w_state = r_state;
    w_stb   = r_stb;
    w_we    = r_we;
    w_addr  = r_addr;
    w_dout  = r_dout;
    w_pass  = r_pass;
    // first_err_addr latches only on the very first mismatch of a run
    w_err   = (w_mis && r_err != 16'hFFFF) ? r_err + 16'd1 : r_err;
    w_first = (w_mis && r_err == '0) ? r_addr : r_first;
    w_cyc   = (w_busy && r_cyc != 32'hFFFFFFFF) ? r_cyc + 32'd1 : r_cyc;
    if ((r_state == IDLE || r_state == DONE) && start) begin
      w_state = WRITE;
      w_stb   = 1'b1;
      w_we    = 1'b1;
      w_addr  = '0;
      w_dout  = pat('0);
      w_pass  = 1'b0;
      w_err   = '0;
      w_first = '0;
      w_cyc   = '0;
    end else if (r_state == WRITE && w_xfer) begin
      w_state = w_last ? READ : WRITE;
      w_we    = !w_last;
      w_addr  = w_last ? '0 : w_next;
      w_dout  = w_last ? r_dout : pat(w_next);
    end else if (r_state == READ && w_xfer) begin
      // the last word's compare is already folded into w_err here
      w_state = w_last ? DONE : READ;
      w_stb   = !w_last;
      w_addr  = w_last ? r_addr : w_next;
      w_pass  = w_last && w_err == '0;
    end
  end
  assign mem_stb        = r_stb;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_data_out   = r_dout;
  assign busy           = w_busy;
  assign done           = r_state == DONE;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_err_addr = r_first;
  assign cycle_count    = r_cyc;
endmodule
